// File: rtl/plic_arb_pkg.sv
// plic_arb_pkg -- shared types and constants for the PLIC register-bus arbiter.
// Rev 1.0
`default_nettype none

package plic_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } arb_state_e;

   localparam reg_intf::reg_intf_resp_d32 RESP_IDLE     = '0;
   localparam logic [31:0]                TIMEOUT_RDATA = 32'h0;

endpackage

`default_nettype wire

// File: rtl/reg_intf.sv
// reg_intf -- generic 32-bit register-bus request/response types.
// Rev 1.0
`default_nettype none

package reg_intf;

   typedef struct packed {
      logic [31:0] addr;
      logic        write;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        valid;
   } reg_intf_req_a32_d32;

   typedef struct packed {
      logic        ready;
      logic [31:0] rdata;
      logic        error;
   } reg_intf_resp_d32;

endpackage

`default_nettype wire

// File: rtl/plic_rr_pick.sv
// plic_rr_pick -- combinational round-robin picker, scanning from rr_ptr+1 upward.
// Rev 1.0
`default_nettype none

module plic_rr_pick
   import plic_arb_pkg::*;
#(
   parameter int N_REQ = 2,
   parameter int IDXW  = 1
) (
   input  logic [N_REQ-1:0] valid,
   input  logic [IDXW-1:0]  rr_ptr,
   output logic             found,
   output logic [IDXW-1:0]  idx
);

   logic [IDXW-1:0] cand;

   always_comb begin
      found = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int i = 1; i <= N_REQ; i++) begin
         cand = IDXW'((int'(rr_ptr) + i) % N_REQ);
         if (!found && valid[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/plic_reg_arbiter.sv
// plic_reg_arbiter -- round-robin sharing of the PLIC register port with a per-access watchdog.
// Rev 1.0
`default_nettype none

module plic_reg_arbiter
   import reg_intf::*;
   import plic_arb_pkg::*;
#(
   parameter int N_REQ       = 2,
   parameter int TIMEOUT_CYC = 1024,
   parameter int IDXW        = (N_REQ > 1) ? $clog2(N_REQ) : 1,
   parameter int TOW         = $clog2(TIMEOUT_CYC + 1)
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  reg_intf_req_a32_d32 [N_REQ-1:0]       req_i,
   output reg_intf_resp_d32    [N_REQ-1:0]       resp_o,
   output reg_intf_req_a32_d32                   plic_req_o,
   input  reg_intf_resp_d32                      plic_resp_i,
   output logic                                  busy_o,
   output logic [IDXW-1:0]                       grant_o,
   output logic                                  timeout_o
);

   arb_state_e        state;
   logic [IDXW-1:0]   rr_ptr;
   logic [TOW-1:0]    wdog;
   logic [N_REQ-1:0]  req_valid;
   logic              pick_found;
   logic [IDXW-1:0]   pick_idx;

   always_comb begin
      req_valid = '0;
      for (int i = 0; i < N_REQ; i++) begin
         req_valid[i] = req_i[i].valid;
      end
   end

   plic_rr_pick #(
      .N_REQ (N_REQ),
      .IDXW  (IDXW)
   ) u_pick (
      .valid  (req_valid),
      .rr_ptr (rr_ptr),
      .found  (pick_found),
      .idx    (pick_idx)
   );

   assign busy_o = (state != IDLE);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state      <= IDLE;
         rr_ptr     <= IDXW'(N_REQ - 1);
         plic_req_o <= '0;
         grant_o    <= '0;
         timeout_o  <= 1'b0;
         wdog       <= '0;
         for (int i = 0; i < N_REQ; i++) begin
            resp_o[i] <= RESP_IDLE;
         end
      end else begin
         timeout_o <= 1'b0;
         for (int i = 0; i < N_REQ; i++) begin
            resp_o[i] <= RESP_IDLE;
         end
         case (state)
            IDLE: begin
               if (pick_found) begin
                  // Whole request is captured so later master changes cannot leak onto the PLIC bus
                  plic_req_o       <= req_i[pick_idx];
                  plic_req_o.valid <= 1'b1;
                  grant_o          <= pick_idx;
                  wdog             <= '0;
                  state            <= BUSY;
               end
            end
            BUSY: begin
               if (plic_resp_i.ready) begin
                  plic_req_o.valid        <= 1'b0;
                  resp_o[grant_o].ready   <= 1'b1;
                  resp_o[grant_o].rdata   <= plic_resp_i.rdata;
                  resp_o[grant_o].error   <= plic_resp_i.error;
                  wdog                    <= '0;
                  state                   <= RESP;
               end else if (wdog == TOW'(TIMEOUT_CYC - 1)) begin
                  plic_req_o.valid        <= 1'b0;
                  resp_o[grant_o].ready   <= 1'b1;
                  resp_o[grant_o].rdata   <= TIMEOUT_RDATA;
                  resp_o[grant_o].error   <= 1'b1;
                  timeout_o               <= 1'b1;
                  wdog                    <= '0;
                  state                   <= RESP;
               end else begin
                  wdog <= wdog + 1'b1;
               end
            end
            RESP: begin
               rr_ptr <= grant_o;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_plic_reg_arbiter.sv
// tb_plic_reg_arbiter -- directed self-checking bench for plic_reg_arbiter.
// Rev 1.0
`default_nettype none

module tb_plic_reg_arbiter;
   import reg_intf::*;

   logic                           clk;
   logic                           rst;
   reg_intf_req_a32_d32 [1:0]      req;
   reg_intf_resp_d32    [1:0]      resp;
   reg_intf_req_a32_d32            plic_req;
   reg_intf_resp_d32               plic_resp;
   logic                           busy;
   logic [0:0]                     grant;
   logic                           timeout;

   int          vectors;
   int          miscompares;
   bit          plic_never;
   int          plic_delay;
   logic [31:0] plic_rdata;
   int          vcnt;
   logic        plic_rdy;

   plic_reg_arbiter #(
      .N_REQ       (2),
      .TIMEOUT_CYC (16)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_i       (req),
      .resp_o      (resp),
      .plic_req_o  (plic_req),
      .plic_resp_i (plic_resp),
      .busy_o      (busy),
      .grant_o     (grant),
      .timeout_o   (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // PLIC model: ready after plic_delay cycles of valid, unless plic_never is set
   always @(posedge clk or posedge rst) begin
      if (rst || !plic_req.valid) vcnt <= 0;
      else                        vcnt <= vcnt + 1;
   end

   always_comb begin
      plic_rdy        = plic_req.valid && !plic_never && (vcnt == plic_delay);
      plic_resp       = '0;
      plic_resp.ready = plic_rdy;
      plic_resp.rdata = plic_rdy ? plic_rdata : 32'hDEAD_BEEF;
      plic_resp.error = 1'b0;
   end

   task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      req         = '0;
      plic_never  = 1'b0;
      plic_delay  = 0;
      plic_rdata  = 32'h0;
      repeat (2) tick();
      check_vec("rst_busy",    busy, 0);
      check_vec("rst_grant",   grant, 0);
      check_vec("rst_timeout", timeout, 0);
      check_vec("rst_plicreq", plic_req, 0);
      check_vec("rst_resp0",   resp[0], 0);
      check_vec("rst_resp1",   resp[1], 0);
      rst = 1'b0;

      // single read, zero-wait PLIC
      req[0].addr  = 32'h0020_0004;
      req[0].write = 1'b0;
      req[0].wstrb = 4'hF;
      req[0].valid = 1'b1;
      plic_rdata   = 32'h5;
      check_vec("t1_idle_busy", busy, 0);
      tick();
      check_vec("t1_plic_valid", plic_req.valid, 1);
      check_vec("t1_plic_addr",  plic_req.addr, 32'h0020_0004);
      check_vec("t1_grant",      grant, 0);
      check_vec("t1_early_rdy",  resp[0].ready, 0);
      req[0].valid = 1'b0;
      tick();
      check_vec("t1_rdy",        resp[0].ready, 1);
      check_vec("t1_rdata",      resp[0].rdata, 32'h5);
      check_vec("t1_err",        resp[0].error, 0);
      check_vec("t1_resp1",      resp[1], 0);
      check_vec("t1_plic_drop",  plic_req.valid, 0);
      tick();
      check_vec("t1_resp0_clr",  resp[0], 0);
      check_vec("t1_back_idle",  busy, 0);

      // contention from reset: grants alternate 0,1,0,1 on a 3-cycle cadence
      req[0].addr  = 32'h0000_0100;
      req[0].valid = 1'b1;
      req[1].addr  = 32'h0000_0200;
      req[1].write = 1'b0;
      req[1].wstrb = 4'hF;
      req[1].valid = 1'b1;
      plic_rdata   = 32'hA5;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         check_vec($sformatf("t2_grant%0d", k), grant, k % 2);
         check_vec($sformatf("t2_addr%0d", k), plic_req.addr, (k % 2) ? 32'h200 : 32'h100);
         tick();
         check_vec($sformatf("t2_rdy%0d", k), resp[k % 2].ready, 1);
         check_vec($sformatf("t2_other%0d", k), resp[1 - (k % 2)], 0);
         tick();
         check_vec($sformatf("t2_idle%0d", k), busy, 0);
      end
      req[0].valid = 1'b0;
      req[1].valid = 1'b0;

      // stable forwarding across a slow PLIC
      req[1].addr  = 32'h0000_0004;
      req[1].write = 1'b1;
      req[1].wdata = 32'h7;
      req[1].valid = 1'b1;
      plic_delay   = 5;
      plic_rdata   = 32'h0;
      tick();
      check_vec("t3_grant", grant, 1);
      check_vec("t3_write", plic_req.write, 1);
      check_vec("t3_wdata1", plic_req.wdata, 32'h7);
      req[1].wdata = 32'hFF;
      req[1].valid = 1'b0;
      for (int i = 2; i <= 6; i++) begin
         tick();
         check_vec($sformatf("t3_wdata%0d", i), plic_req.wdata, 32'h7);
         check_vec($sformatf("t3_valid%0d", i), plic_req.valid, 1);
      end
      tick();
      check_vec("t3_rdy", resp[1].ready, 1);
      check_vec("t3_err", resp[1].error, 0);
      tick();

      // watchdog abort after 16 BUSY cycles, then master1 is served
      plic_never   = 1'b1;
      plic_delay   = 0;
      req[0].valid = 1'b1;
      req[1].write = 1'b0;
      req[1].valid = 1'b1;
      tick();
      check_vec("t4_grant0", grant, 0);
      for (int i = 1; i <= 16; i++) begin
         check_vec($sformatf("t4_noto%0d", i), timeout, 0);
         check_vec($sformatf("t4_valid%0d", i), plic_req.valid, 1);
         tick();
      end
      check_vec("t4_timeout", timeout, 1);
      check_vec("t4_rdy",     resp[0].ready, 1);
      check_vec("t4_err",     resp[0].error, 1);
      check_vec("t4_rdata",   resp[0].rdata, 32'h0);
      check_vec("t4_resp1",   resp[1], 0);
      req[0].valid = 1'b0;
      plic_never   = 1'b0;
      tick();
      check_vec("t4_pulse_end", timeout, 0);
      check_vec("t4_idle",      busy, 0);
      tick();
      check_vec("t4_next_grant", grant, 1);
      req[1].valid = 1'b0;
      tick();
      check_vec("t4_rdy1", resp[1].ready, 1);
      tick();

      // ready lands exactly in the timeout cycle
      plic_delay   = 15;
      plic_rdata   = 32'h1234_5678;
      req[0].valid = 1'b1;
      tick();
      check_vec("t5_grant", grant, 0);
      req[0].valid = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         check_vec($sformatf("t5_valid%0d", i), plic_req.valid, 1);
         tick();
      end
      check_vec("t5_timeout", timeout, 0);
      check_vec("t5_rdy",     resp[0].ready, 1);
      check_vec("t5_err",     resp[0].error, 0);
      check_vec("t5_rdata",   resp[0].rdata, 32'h1234_5678);
      tick();

      // asynchronous reset while BUSY
      plic_never   = 1'b1;
      plic_delay   = 0;
      req[1].valid = 1'b1;
      tick();
      check_vec("t6_grant1", grant, 1);
      tick();
      tick();
      #1 rst = 1'b1;
      #1;
      check_vec("t6_valid_drop", plic_req.valid, 0);
      check_vec("t6_busy_drop",  busy, 0);
      check_vec("t6_resp1",      resp[1], 0);
      req[1].valid = 1'b0;
      tick();
      rst = 1'b0;
      check_vec("t6_resp1_after", resp[1], 0);
      plic_never   = 1'b0;
      req[0].valid = 1'b1;
      req[1].valid = 1'b1;
      tick();
      check_vec("t6_grant_after", grant, 0);
      req[0].valid = 1'b0;
      req[1].valid = 1'b0;
      tick();
      check_vec("t6_rdy0", resp[0].ready, 1);
      check_vec("t6_no_rdy1", resp[1].ready, 0);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
